// File: rtl/edge_ptr_addr_gen.sv
// Edge-list pointer address generator: one tile-range command in, one byte
// address per tile out, via a credit-gated multiply pipeline and an output FIFO.
module edge_ptr_addr_gen #(
    parameter int MUL_LAT    = 3,
    parameter int ADDR_W     = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [15:0]       cmd_tile_start,
    input  logic [15:0]       cmd_tile_count,
    input  logic [13:0]       cmd_stride,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] addr_data,
    output logic              addr_last,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer occurs on a rising edge where valid and ready are
    // both high; a raised valid holds its payload stable until it is taken.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam int CW   = $clog2(FIFO_DEPTH + MUL_LAT + 1);
    localparam int BODY = FIFO_DEPTH - 1;
    localparam int PW   = (BODY > 1) ? $clog2(BODY) : 1;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q;
    logic [13:0]        stride_q;
    logic [15:0]        count_q, k_q, t_q;

    logic [MUL_LAT-1:0] pv_q, pl_q;
    logic signed [29:0] prod_q [MUL_LAT];
    logic signed [29:0] prod_d, t_ext, s_ext;

    logic               head_valid_q, head_last_q;
    logic [ADDR_W-1:0]  head_data_q;
    logic [ADDR_W-1:0]  body_data [BODY];
    logic [BODY-1:0]    body_last;
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      body_cnt_q;

    logic [CW-1:0]      inflight, fifo_count, occ_after;
    logic               pop, issue, is_last, cmd_fire;
    logic               wr_en, wr_last, head_free, pull, push_body;
    logic [ADDR_W-1:0]  wr_data, prod_ext;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(BODY - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cmd_ready  = (state_q == S_IDLE) && ap_rst_n;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;
    assign addr_valid = head_valid_q;
    assign addr_data  = head_data_q;
    assign addr_last  = head_last_q;
    assign pop        = head_valid_q && addr_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MUL_LAT; i++) inflight = inflight + CW'(pv_q[i]);
    end

    // Credit covers everything issued but not yet consumed; a same-cycle pop frees a slot.
    assign fifo_count = CW'(head_valid_q) + body_cnt_q;
    assign occ_after  = inflight + fifo_count - CW'(pop);
    assign is_last    = (k_q == count_q - 16'd1);
    assign issue      = (state_q == S_RUN) && (occ_after < CW'(FIFO_DEPTH));

    // |t * stride| < 2^29, so a 30-bit signed product is exact.
    assign t_ext  = {{14{t_q[15]}}, t_q};
    assign s_ext  = {16'd0, stride_q};
    assign prod_d = t_ext * s_ext;

    assign wr_en     = pv_q[MUL_LAT-1];
    assign wr_last   = pl_q[MUL_LAT-1];
    assign prod_ext  = {{(ADDR_W-30){prod_q[MUL_LAT-1][29]}}, prod_q[MUL_LAT-1]};
    assign wr_data   = base_q + {prod_ext[ADDR_W-4:0], 3'b000};
    assign head_free = !head_valid_q || pop;
    assign pull      = head_free && (body_cnt_q != '0);
    assign push_body = wr_en && !(head_free && (body_cnt_q == '0));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_fire && (cmd_tile_count != 16'd0)) state_d = S_RUN;
            S_RUN:   if (issue && is_last) state_d = S_DRAIN;
            S_DRAIN: if ((inflight == '0) && (fifo_count == CW'(pop))) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            base_q   <= '0;
            stride_q <= '0;
            count_q  <= '0;
            k_q      <= '0;
            t_q      <= '0;
        end else if (cmd_fire) begin
            base_q   <= cmd_base;
            stride_q <= cmd_stride;
            count_q  <= cmd_tile_count;
            k_q      <= '0;
            t_q      <= cmd_tile_start;
        end else if (issue) begin
            t_q <= t_q + 16'd1;
            k_q <= k_q + 16'd1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pv_q <= '0;
            pl_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= '0;
        end else begin
            pv_q[0]   <= issue;
            pl_q[0]   <= issue && is_last;
            prod_q[0] <= prod_d;
            for (int i = 1; i < MUL_LAT; i++) begin
                pv_q[i]   <= pv_q[i-1];
                pl_q[i]   <= pl_q[i-1];
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    // Head register is the visible word; the body ring only fills behind an occupied head.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            head_valid_q <= 1'b0;
            head_last_q  <= 1'b0;
            head_data_q  <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            body_cnt_q   <= '0;
        end else begin
            if (head_free) begin
                if (pull) begin
                    head_valid_q <= 1'b1;
                    head_data_q  <= body_data[rd_ptr_q];
                    head_last_q  <= body_last[rd_ptr_q];
                end else if (wr_en) begin
                    head_valid_q <= 1'b1;
                    head_data_q  <= wr_data;
                    head_last_q  <= wr_last;
                end else begin
                    head_valid_q <= 1'b0;
                end
            end
            if (pull)      rd_ptr_q <= next_ptr(rd_ptr_q);
            if (push_body) wr_ptr_q <= next_ptr(wr_ptr_q);
            body_cnt_q <= body_cnt_q + CW'(push_body) - CW'(pull);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (push_body) begin
            body_data[wr_ptr_q] <= wr_data;
            body_last[wr_ptr_q] <= wr_last;
        end
    end

endmodule

// File: tb/tb_edge_ptr_addr_gen.sv
// Bench for edge_ptr_addr_gen: directed command vectors with hand-computed
// addresses queued as expectations, checked by an independent output monitor.
module tb_edge_ptr_addr_gen;

    localparam int MUL_LAT    = 3;
    localparam int ADDR_W     = 64;
    localparam int FIFO_DEPTH = 8;

    logic              ap_clk         = 1'b0;
    logic              ap_rst_n       = 1'b0;
    logic              cmd_valid      = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base       = '0;
    logic [15:0]       cmd_tile_start = '0;
    logic [15:0]       cmd_tile_count = '0;
    logic [13:0]       cmd_stride     = '0;
    logic              addr_valid;
    logic              addr_ready     = 1'b1;
    logic [ADDR_W-1:0] addr_data;
    logic              addr_last;
    logic              busy;
    logic [1:0]        dbg_state;

    int ready_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random per cycle
    int cmp_cnt    = 0;
    int err_cnt    = 0;
    logic [ADDR_W:0] exp_q[$];

    edge_ptr_addr_gen #(
        .MUL_LAT   (MUL_LAT),
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_base      (cmd_base),
        .cmd_tile_start(cmd_tile_start),
        .cmd_tile_count(cmd_tile_count),
        .cmd_stride    (cmd_stride),
        .addr_valid    (addr_valid),
        .addr_ready    (addr_ready),
        .addr_data     (addr_data),
        .addr_last     (addr_last),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock and ready driver ----------------
    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) begin
        #2;
        case (ready_mode)
            0:       addr_ready = 1'b0;
            1:       addr_ready = 1'b1;
            default: addr_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [ADDR_W:0] got, input logic [ADDR_W:0] want);
        cmp_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic last);
        exp_q.push_back({last, a});
    endtask

    // Reference: exact 64-bit integer arithmetic on the tile index.
    task automatic push_model(input logic [63:0] b, input logic [15:0] s,
                              input logic [15:0] c, input logic [13:0] st);
        logic signed [15:0] t;
        longint             p;
        logic [63:0]        a;
        for (int k = 0; k < int'(c); k++) begin
            t = s + 16'(k);
            p = longint'(t) * longint'({50'd0, st});
            a = b + 64'(p * 8);
            exp_q.push_back({(k == int'(c) - 1), a});
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge ap_clk) begin
        if (ap_rst_n && addr_valid && addr_ready) begin
            if (exp_q.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL unexpected_addr: got %0h last %0b, none expected", addr_data, addr_last);
            end else begin
                check("addr_stream", {addr_last, addr_data}, exp_q.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_cmd(input logic [63:0] b, input logic [15:0] s,
                            input logic [15:0] c, input logic [13:0] st);
        bit ok = 1'b0;
        cmd_base       = b;
        cmd_tile_start = s;
        cmd_tile_count = c;
        cmd_stride     = st;
        cmd_valid      = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge ap_clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("cmd_accept", 65'(ok), 65'd1);
        @(posedge ap_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge ap_clk);
            if (exp_q.size() == 0 && cmd_ready && !addr_valid) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_drain"}, 65'(done), 65'd1);
        @(posedge ap_clk);
        #1;
    endtask

    task automatic report();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    endtask

    initial begin
        #800000;
        err_cnt++;
        $display("FAIL watchdog: time limit reached with %0d expectations pending", exp_q.size());
        report();
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int vcnt;

        // Reset state
        repeat (3) @(negedge ap_clk);
        check("rst_cmd_ready", 65'(cmd_ready), 65'd0);
        check("rst_addr_valid", 65'(addr_valid), 65'd0);
        check("rst_addr_data", 65'(addr_data), 65'd0);
        check("rst_addr_last", 65'(addr_last), 65'd0);
        check("rst_busy", 65'(busy), 65'd0);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check("post_rst_cmd_ready", 65'(cmd_ready), 65'd1);
        @(posedge ap_clk);
        #1;

        // Basic stream with cycle-exact timing
        push_exp(64'h1640, 1'b0);
        push_exp(64'h1960, 1'b0);
        push_exp(64'h1C80, 1'b1);
        send_cmd(64'h1000, 16'sd2, 16'd3, 14'd100);
        for (int n = 1; n <= 8; n++) begin
            @(negedge ap_clk);
            check($sformatf("t1_valid_c%0d", n), 65'(addr_valid), 65'(n >= 5 && n <= 7));
            check($sformatf("t1_busy_c%0d", n), 65'(busy), 65'(n <= 7));
            check($sformatf("t1_ready_c%0d", n), 65'(cmd_ready), 65'(n == 8));
        end
        wait_idle("t1");

        // Negative start: signed product and sign extension
        push_exp(64'hB0, 1'b0);
        push_exp(64'hD8, 1'b1);
        send_cmd(64'h100, -16'sd2, 16'd2, 14'd5);
        wait_idle("t2");

        // Index wrap 32767 -> -32768 with maximum stride
        push_exp(64'd4294574088, 1'b0);
        push_exp(64'hFFFF_FFFF_0004_0000, 1'b1);
        send_cmd(64'h0, 16'sd32767, 16'd2, 14'd16383);
        wait_idle("t3");

        // Zero-count command produces nothing
        send_cmd(64'h5000, 16'sd7, 16'd0, 14'd9);
        for (int n = 1; n <= 3; n++) begin
            @(negedge ap_clk);
            check($sformatf("c0_busy_c%0d", n), 65'(busy), 65'd0);
            check($sformatf("c0_ready_c%0d", n), 65'(cmd_ready), 65'd1);
            check($sformatf("c0_valid_c%0d", n), 65'(addr_valid), 65'd0);
        end
        @(posedge ap_clk);
        #1;

        // Backpressure: FIFO fills to depth, issue stops, then drains gap-free
        ready_mode = 0;
        for (int i = 0; i < 16; i++) push_exp(64'(i * 8), i == 15);
        send_cmd(64'h0, 16'sd0, 16'd16, 14'd1);
        repeat (40) @(posedge ap_clk);
        @(negedge ap_clk);
        check("bp_fifo_count", 65'(dut.fifo_count), 65'(FIFO_DEPTH));
        check("bp_inflight", 65'(dut.inflight), 65'd0);
        check("bp_busy", 65'(busy), 65'd1);
        check("bp_pending", 65'(exp_q.size()), 65'd16);
        @(posedge ap_clk);
        #1;
        ready_mode = 1;
        vcnt = 0;
        for (int n = 0; n < 16; n++) begin
            @(negedge ap_clk);
            if (addr_valid) vcnt++;
        end
        check("bp_no_gaps", 65'(vcnt), 65'd16);
        wait_idle("bp");

        // Reset mid-RUN after some addresses have been delivered
        push_model(64'h2000, 16'sd0, 16'd16, 14'd3);
        send_cmd(64'h2000, 16'sd0, 16'd16, 14'd3);
        repeat (7) @(posedge ap_clk);
        #3;
        ap_rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_ready", 65'(cmd_ready), 65'd0);
        check("mid_rst_addr_valid", 65'(addr_valid), 65'd0);
        check("mid_rst_addr_data", 65'(addr_data), 65'd0);
        check("mid_rst_addr_last", 65'(addr_last), 65'd0);
        check("mid_rst_busy", 65'(busy), 65'd0);
        exp_q.delete();
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        push_exp(64'hB0, 1'b0);
        push_exp(64'hD8, 1'b1);
        send_cmd(64'h100, -16'sd2, 16'd2, 14'd5);
        wait_idle("after_rst");

        // Many commands under random backpressure against the reference model
        ready_mode = 2;
        for (int n = 0; n < 1000; n++) begin
            logic [63:0] b;
            logic [15:0] s, c;
            logic [13:0] st;
            b  = {$urandom, $urandom};
            s  = 16'($urandom);
            c  = 16'($urandom_range(0, 4));
            st = 14'($urandom);
            push_model(b, s, c, st);
            send_cmd(b, s, c, st);
            wait_idle("rand");
        end
        ready_mode = 1;

        check("final_queue_empty", 65'(exp_q.size()), 65'd0);
        report();
        $finish;
    end

endmodule
